// File: rtl/pe_controller.sv
// Weight-stationary NxN systolic matrix multiplier with its IDLE/RUN sequencer.
// Streams a snapshot of A through the loaded weight grid and publishes C = A x W atomically.
//
// state | meaning
// IDLE  | waiting for compute; PE pipeline held at zero
// RUN   | pass in flight, r_cnt counts 0..3N-1
module pe_controller #(
    parameter int ARRAY_SIZE             = 8,
    parameter int COMPUTE_DATA_WIDTH     = 4,
    parameter int ACCUMULATOR_DATA_WIDTH = 16,
    parameter int BUFFER_WORD_SIZE       = 16,
    parameter int NUM_COMPUTE_LANES      = 4
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic                                     compute,
    input  logic                                     load_en,
    input  logic signed [COMPUTE_DATA_WIDTH-1:0]     datas_arr   [ARRAY_SIZE*ARRAY_SIZE],
    input  logic signed [COMPUTE_DATA_WIDTH-1:0]     weights_in  [ARRAY_SIZE*ARRAY_SIZE],
    output logic signed [ACCUMULATOR_DATA_WIDTH-1:0] results_arr [ARRAY_SIZE*ARRAY_SIZE]
);
    localparam int N     = ARRAY_SIZE;
    localparam int NN    = N * N;
    localparam int CW    = COMPUTE_DATA_WIDTH;
    localparam int AW    = ACCUMULATOR_DATA_WIDTH;
    localparam int CNT_W = $clog2(3 * N + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(3 * N - 1);

    if (NUM_COMPUTE_LANES != BUFFER_WORD_SIZE / COMPUTE_DATA_WIDTH) begin : g_bad_lanes
        $error("NUM_COMPUTE_LANES must equal BUFFER_WORD_SIZE / COMPUTE_DATA_WIDTH");
    end

    typedef enum logic {IDLE, RUN} state_t;

    state_t             r_state, w_state_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic               w_start, w_done;

    logic [CW-1:0]      r_w      [NN];
    logic [CW-1:0]      r_data   [NN];
    logic [AW-1:0]      r_res_buf[NN];
    logic [CW-1:0]      r_a      [N][N-1];
    logic [AW-1:0]      r_p      [N][N];
    logic [CW-1:0]      w_a_in   [N][N];
    logic [AW-1:0]      w_psum_in[N][N];
    logic [2*CW-1:0]    w_prod   [N][N];
    logic [AW-1:0]      w_mac    [N][N];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= (r_state == RUN) ? r_cnt + 1'b1 : '0;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            IDLE: begin
                if (compute && !load_en) begin
                    w_state_nxt = RUN;
                    w_start     = 1'b1;
                end
            end
            RUN: begin
                if (load_en) begin
                    w_state_nxt = IDLE;
                end else if (r_cnt == LAST_CNT) begin
                    w_state_nxt = IDLE;
                    w_done      = 1'b1;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Row k is fed A[i][k] on relative cycle i+k; everything else in the grid is nearest-neighbour.
    always_comb begin
        for (int k = 0; k < N; k++) begin
            for (int j = 0; j < N; j++) begin
                w_a_in[k][j]    = '0;
                w_psum_in[k][j] = '0;
            end
        end
        for (int i = 0; i < N; i++) begin
            for (int k = 0; k < N; k++) begin
                if (int'(r_cnt) == i + k) w_a_in[k][0] = r_data[i*N+k];
            end
        end
        for (int k = 0; k < N; k++) begin
            for (int j = 1; j < N; j++) w_a_in[k][j] = r_a[k][j-1];
        end
        for (int k = 1; k < N; k++) begin
            for (int j = 0; j < N; j++) w_psum_in[k][j] = r_p[k-1][j];
        end
        for (int k = 0; k < N; k++) begin
            for (int j = 0; j < N; j++) begin
                // Low 2*CW bits of the sign-extended operands give the exact signed product.
                w_prod[k][j] = {{CW{w_a_in[k][j][CW-1]}}, w_a_in[k][j]}
                             * {{CW{r_w[k*N+j][CW-1]}}, r_w[k*N+j]};
                w_mac[k][j]  = w_psum_in[k][j] + {{(AW-2*CW){w_prod[k][j][2*CW-1]}}, w_prod[k][j]};
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int x = 0; x < NN; x++) begin
                r_w[x]         <= '0;
                r_data[x]      <= '0;
                r_res_buf[x]   <= '0;
                results_arr[x] <= '0;
            end
            for (int k = 0; k < N; k++) begin
                for (int j = 0; j < N; j++) r_p[k][j] <= '0;
                for (int j = 0; j < N - 1; j++) r_a[k][j] <= '0;
            end
        end else begin
            if (load_en) begin
                for (int x = 0; x < NN; x++) r_w[x] <= weights_in[x];
            end
            if (w_start) begin
                for (int x = 0; x < NN; x++) r_data[x] <= datas_arr[x];
            end
            if (r_state == RUN) begin
                for (int k = 0; k < N; k++) begin
                    for (int j = 0; j < N; j++) r_p[k][j] <= w_mac[k][j];
                    for (int j = 0; j < N - 1; j++) r_a[k][j] <= w_a_in[k][j];
                end
                // C[i][j] leaves the bottom row on relative cycle i+j+N.
                for (int i = 0; i < N; i++) begin
                    for (int j = 0; j < N; j++) begin
                        if (int'(r_cnt) == i + j + N) r_res_buf[i*N+j] <= r_p[N-1][j];
                    end
                end
            end else begin
                for (int k = 0; k < N; k++) begin
                    for (int j = 0; j < N; j++) r_p[k][j] <= '0;
                    for (int j = 0; j < N - 1; j++) r_a[k][j] <= '0;
                end
            end
            if (w_done) begin
                for (int x = 0; x < NN; x++) results_arr[x] <= r_res_buf[x];
            end
        end
    end
endmodule

// File: tb/tb_pe_controller.sv
// Directed bench for pe_controller: reset, canonical, identity, extremes, abort and snapshot timing.
module tb_pe_controller;
    localparam int N  = 8;
    localparam int NN = N * N;

    logic                clk = 1'b0;
    logic                rst;
    logic                compute;
    logic                load_en;
    logic signed [3:0]   datas_arr   [NN];
    logic signed [3:0]   weights_in  [NN];
    logic signed [15:0]  results_arr [NN];

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    pe_controller #(
        .ARRAY_SIZE(8), .COMPUTE_DATA_WIDTH(4), .ACCUMULATOR_DATA_WIDTH(16),
        .BUFFER_WORD_SIZE(16), .NUM_COMPUTE_LANES(4)
    ) dut (
        .clk(clk), .rst(rst), .compute(compute), .load_en(load_en),
        .datas_arr(datas_arr), .weights_in(weights_in), .results_arr(results_arr)
    );

    task automatic chk_val(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic fill(input int a, input int w);
        for (int x = 0; x < NN; x++) begin
            datas_arr[x]  = 4'(a);
            weights_in[x] = 4'(w);
        end
    endtask

    task automatic fill_data(input int a);
        for (int x = 0; x < NN; x++) datas_arr[x] = 4'(a);
    endtask

    task automatic load_w();
        load_en = 1'b1;
        step(1);
        load_en = 1'b0;
    endtask

    // Returns just after edge S.
    task automatic start_pass();
        compute = 1'b1;
        step(1);
        compute = 1'b0;
    endtask

    task automatic chk_all(input string tag, input int exp);
        for (int x = 0; x < NN; x++) chk_val($sformatf("%s[%0d]", tag, x), int'(results_arr[x]), exp);
    endtask

    task automatic chk_canon(input string tag);
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                chk_val($sformatf("%s[%0d][%0d]", tag, i, j), int'(results_arr[i*N+j]), (j - 1) * 20);
            end
        end
    endtask

    initial begin
        rst     = 1'b0;
        compute = 1'b1;
        load_en = 1'b1;
        fill(5, 3);
        step(3);
        chk_all("reset", 0);

        load_en = 1'b0;
        rst     = 1'b1;
        step(3 * N + 4);
        chk_all("no_weights", 0);

        compute = 1'b0;
        for (int x = 0; x < NN; x++) begin
            datas_arr[x]  = 4'((x % 8) - 1);
            weights_in[x] = 4'((x % 8) - 1);
        end
        load_en = 1'b1;
        step(2);
        load_en = 1'b0;
        compute = 1'b1;
        step(3 * N + 1);
        chk_canon("canon");
        step(10000);
        chk_canon("canon_long");
        compute = 1'b0;
        step(3 * N + 2);

        for (int i = 0; i < N; i++) begin
            for (int k = 0; k < N; k++) begin
                datas_arr[i*N+k]  = 4'(i - k);
                weights_in[i*N+k] = (i == k) ? 4'sd1 : 4'sd0;
            end
        end
        load_w();
        start_pass();
        step(3 * N);
        chk_val("ident_c70", int'(results_arr[7*N+0]), 7);
        chk_val("ident_c07", int'(results_arr[0*N+7]), -7);
        chk_val("ident_c52", int'(results_arr[5*N+2]), 3);
        chk_val("ident_c33", int'(results_arr[3*N+3]), 0);
        chk_val("ident_c16", int'(results_arr[1*N+6]), -5);

        fill(-8, -8);
        load_w();
        start_pass();
        step(3 * N);
        chk_all("ext_neg", 512);

        fill(7, -8);
        load_w();
        start_pass();
        step(3 * N);
        chk_all("ext_mix", -448);

        fill_data(1);
        start_pass();
        step(4);
        for (int x = 0; x < NN; x++) weights_in[x] = 4'sd1;
        load_en = 1'b1;
        step(1);
        load_en = 1'b0;
        step(3 * N);
        chk_all("abort_hold", -448);
        start_pass();
        step(3 * N);
        chk_all("abort_next", 8);

        fill_data(2);
        start_pass();
        fill_data(3);
        step(3 * N - 1);
        chk_all("snap_pre", 8);
        step(1);
        chk_all("snap_done", 16);
        step(5);
        chk_all("snap_hold", 16);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
